// File: rtl/zynq_frame_packer.sv
// Packs 12-bit digitizer FIFO samples in pairs into 32-bit words and frames them
// with a header and trailer on a valid/ready stream toward the ZYNQ side.
module zynq_frame_packer #(
  parameter int WIDTH    = 12,
  parameter int TO_BITS  = 8,
  parameter int SEQ_BITS = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   FIFO_Q,
  input  logic               FIFO_EMPTY,
  output logic               FIFO_RDREQ,
  input  logic [11:0]        FRAME_LEN,
  input  logic [TO_BITS-1:0] TIMEOUT,
  output logic [31:0]        M_DATA,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic               M_LAST,
  output logic               BUSY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    COLLECT = 3'd2,
    PAD     = 3'd3,
    TRL     = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [31:0]          m_data, m_data_nxt;
  logic                 m_valid, m_valid_nxt;
  logic                 m_last, m_last_nxt;
  logic [SEQ_BITS-1:0]  seq, seq_nxt;
  logic [11:0]          count, count_nxt;
  logic [11:0]          flen, flen_nxt;
  logic [TO_BITS-1:0]   to_cnt, to_cnt_nxt;
  logic [TO_BITS-1:0]   to_lim, to_lim_nxt;
  logic                 in_flight, in_flight_nxt;
  logic [WIDTH-1:0]     s0, s0_nxt;
  logic                 rd;
  logic                 close;

  function automatic logic [31:0] header_word(input logic [SEQ_BITS-1:0] sq);
    return {8'hA5, sq, 12'h000};
  endfunction

  function automatic logic [31:0] data_word(input logic odd, input logic [WIDTH-1:0] hi,
                                            input logic [WIDTH-1:0] lo);
    return {4'hD, 3'b000, odd, hi, lo};
  endfunction

  function automatic logic [31:0] trailer_word(input logic [SEQ_BITS-1:0] sq,
                                               input logic [11:0] nsamp);
    return {8'h5A, sq, nsamp};
  endfunction

  // Next-state, next-output and FIFO read request decode
  always_comb begin
    state_nxt     = state;
    m_data_nxt    = m_data;
    m_valid_nxt   = m_valid;
    m_last_nxt    = m_last;
    seq_nxt       = seq;
    count_nxt     = count;
    flen_nxt      = flen;
    to_cnt_nxt    = to_cnt;
    to_lim_nxt    = to_lim;
    in_flight_nxt = in_flight;
    s0_nxt        = s0;
    rd            = 1'b0;
    close         = 1'b0;
    case (state)
      IDLE: begin
        if (!FIFO_EMPTY) begin
          m_data_nxt  = header_word(seq);
          m_valid_nxt = 1'b1;
          m_last_nxt  = 1'b0;
          flen_nxt    = (FRAME_LEN == 12'd0) ? 12'd1 : FRAME_LEN;
          to_lim_nxt  = TIMEOUT;
          count_nxt   = 12'd0;
          to_cnt_nxt  = {TO_BITS{1'b0}};
          state_nxt   = HDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      HDR: begin
        if (M_READY) begin
          m_valid_nxt = 1'b0;
          state_nxt   = COLLECT;
        end else begin
          state_nxt = HDR;
        end
      end
      COLLECT: begin
        // A read is only issued with no word pending, so capture never meets M_VALID=1
        if (in_flight) begin
          in_flight_nxt = 1'b0;
          count_nxt     = count + 12'd1;
          if (!count[0]) begin
            s0_nxt = FIFO_Q;
          end else begin
            m_data_nxt  = data_word(1'b0, FIFO_Q, s0);
            m_valid_nxt = 1'b1;
          end
        end else if (m_valid) begin
          if (M_READY) begin
            m_valid_nxt = 1'b0;
          end else begin
            m_valid_nxt = 1'b1;
          end
        end else if (count >= flen) begin
          close = 1'b1;
        end else if (!FIFO_EMPTY) begin
          rd            = 1'b1;
          in_flight_nxt = 1'b1;
          to_cnt_nxt    = {TO_BITS{1'b0}};
        end else if (to_cnt == to_lim) begin
          close = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_BITS'(1);
        end
        if (close) begin
          if (count[0]) begin
            m_data_nxt  = data_word(1'b1, {WIDTH{1'b0}}, s0);
            m_valid_nxt = 1'b1;
            state_nxt   = PAD;
          end else begin
            m_data_nxt  = trailer_word(seq, count);
            m_valid_nxt = 1'b1;
            m_last_nxt  = 1'b1;
            state_nxt   = TRL;
          end
        end else begin
          state_nxt = COLLECT;
        end
      end
      PAD: begin
        if (M_READY) begin
          m_data_nxt = trailer_word(seq, count);
          m_last_nxt = 1'b1;
          state_nxt  = TRL;
        end else begin
          state_nxt = PAD;
        end
      end
      TRL: begin
        if (M_READY) begin
          m_valid_nxt = 1'b0;
          m_last_nxt  = 1'b0;
          seq_nxt     = seq + SEQ_BITS'(1);
          count_nxt   = 12'd0;
          to_cnt_nxt  = {TO_BITS{1'b0}};
          state_nxt   = IDLE;
        end else begin
          state_nxt = TRL;
        end
      end
      default: begin
        m_valid_nxt   = 1'b0;
        m_last_nxt    = 1'b0;
        in_flight_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame without a trailer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      m_data    <= 32'h0000_0000;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      seq       <= {SEQ_BITS{1'b0}};
      count     <= 12'd0;
      flen      <= 12'd1;
      to_cnt    <= {TO_BITS{1'b0}};
      to_lim    <= {TO_BITS{1'b0}};
      in_flight <= 1'b0;
      s0        <= {WIDTH{1'b0}};
    end else begin
      state     <= state_nxt;
      m_data    <= m_data_nxt;
      m_valid   <= m_valid_nxt;
      m_last    <= m_last_nxt;
      seq       <= seq_nxt;
      count     <= count_nxt;
      flen      <= flen_nxt;
      to_cnt    <= to_cnt_nxt;
      to_lim    <= to_lim_nxt;
      in_flight <= in_flight_nxt;
      s0        <= s0_nxt;
    end
  end

  assign FIFO_RDREQ = rd;
  assign M_DATA     = m_data;
  assign M_VALID    = m_valid;
  assign M_LAST     = m_last;
  assign BUSY       = (state != IDLE);

endmodule
